// File: rtl/sorter_defs.sv
// ---------------------------------------------------------------------------
// sorter_defs
//   Shared definitions for the sorter_pipe sorting network.
//   - SORT_ASC / SORT_DESC : values of the per-vector direction bit
//   - elem_off()           : element index -> bit offset in a packed vector
//   - key_mask()           : mask keeping bits [w-1:approx_bits] of an element
//                            (elements up to MAX_W bits wide)
// ---------------------------------------------------------------------------
package sorter_defs;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned elem_off(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  function automatic logic [MAX_W-1:0] key_mask(input int unsigned w,
                                                input int unsigned approx_bits);
    logic [MAX_W-1:0] m;
    m = '1;
    if (w < MAX_W) m = (MAX_W'(1) << w) - MAX_W'(1);
    m = m & ~((MAX_W'(1) << approx_bits) - MAX_W'(1));
    return m;
  endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// ---------------------------------------------------------------------------
// sorter_cmp_swap
//   Combinational compare-exchange cell of the odd-even transposition network.
//   Only key bits [W-1:APPROX_BITS] take part in the comparison; equal keys
//   never swap, which keeps the whole network stable.
// Ports:
//   a, b    in  W  elements at the lower / higher index of the pair
//   dir     in  1  SORT_ASC or SORT_DESC
//   lo_idx  out W  element placed at the lower index
//   hi_idx  out W  element placed at the higher index
// ---------------------------------------------------------------------------
module sorter_cmp_swap
  import sorter_defs::*;
#(
  parameter int W           = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] lo_idx,
  output logic [W-1:0] hi_idx
);

  localparam logic [W-1:0] KEY_MASK = W'(key_mask(W, APPROX_BITS));

  logic [W-1:0] key_a;
  logic [W-1:0] key_b;
  logic         swap;

  always_comb begin
    key_a = a & KEY_MASK;
    key_b = b & KEY_MASK;
    swap  = 1'b0;
    case (dir)
      SORT_ASC:  swap = (key_a > key_b);
      SORT_DESC: swap = (key_a < key_b);
      default:   swap = 1'b0;
    endcase
    lo_idx = swap ? b : a;
    hi_idx = swap ? a : b;
  end

endmodule

// File: rtl/sorter_pipe.sv
// ---------------------------------------------------------------------------
// sorter_pipe
//   Fully pipelined odd-even transposition sorter for N unsigned W-bit
//   elements. Round r compares pairs (j, j+1) with j of the same parity as r
//   and registers its result in stage r; an output register follows the last
//   stage, so a vector sampled at edge t is presented after edge t+N.
//   The direction bit and valid bit travel with each vector. enable=0 freezes
//   every register (inputs presented during a stall are dropped).
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active-high
//   enable     in   1    global advance
//   in_valid   in   1    sortIn/dir carry a vector
//   dir        in   1    0 = ascending, 1 = descending
//   sortIn     in   N*W  element i at bits [i*W +: W]
//   out_valid  out  1    sortOut/median hold a new result this cycle
//   sortOut    out  N*W  sorted vector, same packing as sortIn
//   median     out  W    element floor(N/2) of the sorted vector
// ---------------------------------------------------------------------------
module sorter_pipe
  import sorter_defs::*;
#(
  parameter int N           = 9,
  parameter int W           = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           in_valid,
  input  logic           dir,
  input  logic [N*W-1:0] sortIn,
  output logic           out_valid,
  output logic [N*W-1:0] sortOut,
  output logic [W-1:0]   median
);

  // Pair slots per round; the odd rounds of an even N use one slot fewer.
  localparam int          NP      = N / 2;
  localparam int unsigned MED_OFF = elem_off(N / 2, W);

  logic [N*W-1:0] round_in  [N];
  logic [W-1:0]   pair_lo   [N][NP];
  logic [W-1:0]   pair_hi   [N][NP];

  logic [N*W-1:0] stage_d   [N];
  logic [N*W-1:0] stage_q   [N];
  logic           vld_d     [N];
  logic           vld_q     [N];
  logic           dir_d     [N];
  logic           dir_q     [N];

  logic           out_valid_d;
  logic           out_valid_q;
  logic [N*W-1:0] sort_out_d;
  logic [N*W-1:0] sort_out_q;
  logic [W-1:0]   median_d;
  logic [W-1:0]   median_q;

  // Round inputs: round 0 takes the input bus, round r takes stage r-1.
  always_comb begin
    round_in[0] = sortIn;
    vld_d[0]    = in_valid;
    dir_d[0]    = dir;
    for (int r = 1; r < N; r++) begin
      round_in[r] = stage_q[r-1];
      vld_d[r]    = vld_q[r-1];
      dir_d[r]    = dir_q[r-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_round
    for (genvar p = 0; p < NP; p++) begin : g_pair
      localparam int J = 2 * p + (r % 2);
      if (J + 1 < N) begin : g_cs
        sorter_cmp_swap #(
          .W           (W),
          .APPROX_BITS (APPROX_BITS)
        ) u_cmp_swap (
          .a      (round_in[r][elem_off(J, W) +: W]),
          .b      (round_in[r][elem_off(J + 1, W) +: W]),
          .dir    (dir_d[r]),
          .lo_idx (pair_lo[r][p]),
          .hi_idx (pair_hi[r][p])
        );
      end else begin : g_idle
        assign pair_lo[r][p] = '0;
        assign pair_hi[r][p] = '0;
      end
    end
  end

  // Elements not covered by a pair in this round pass straight through.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      stage_d[r] = round_in[r];
      for (int p = 0; p < NP; p++) begin
        if (2 * p + (r % 2) + 1 < N) begin
          stage_d[r][elem_off(2 * p + (r % 2), W) +: W]     = pair_lo[r][p];
          stage_d[r][elem_off(2 * p + (r % 2) + 1, W) +: W] = pair_hi[r][p];
        end
      end
    end
  end

  // Output register reloads only from a valid last stage; bubbles leave the
  // previous result on sortOut/median.
  always_comb begin
    out_valid_d = vld_q[N-1];
    sort_out_d  = vld_q[N-1] ? stage_q[N-1] : sort_out_q;
    median_d    = sort_out_d[MED_OFF +: W];
  end

  // ---- stage 0..N-1 registers and output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        stage_q[r] <= '0;
        vld_q[r]   <= 1'b0;
        dir_q[r]   <= SORT_ASC;
      end
      out_valid_q <= 1'b0;
      sort_out_q  <= '0;
      median_q    <= '0;
    end else if (enable) begin
      for (int r = 0; r < N; r++) begin
        stage_q[r] <= stage_d[r];
        vld_q[r]   <= vld_d[r];
        dir_q[r]   <= dir_d[r];
      end
      out_valid_q <= out_valid_d;
      sort_out_q  <= sort_out_d;
      median_q    <= median_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sortOut   = sort_out_q;
  assign median    = median_q;

endmodule

// File: tb/tb_sorter_pipe.sv
// ---------------------------------------------------------------------------
// tb_sorter_pipe
//   Three sorter_pipe instances (N=9 exact, N=4 approx 4 LSBs, N=4 exact)
//   share control inputs. A behavioural model (N-deep delay line feeding a
//   stable insertion sort) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_sorter_pipe;

  localparam int NK   = 3;
  localparam int NMAX = 9;
  localparam int N_OF  [NK] = '{9, 4, 4};
  localparam int AB_OF [NK] = '{0, 4, 0};

  localparam logic [71:0] V1       = 72'h01_09_12_5a_18_04_05_06_11;
  localparam logic [71:0] EXP_ASC  = 72'h5a_18_12_11_09_06_05_04_01;
  localparam logic [71:0] EXP_DESC = 72'h01_04_05_06_09_11_12_18_5a;
  localparam logic [31:0] VS       = 32'h2a_05_13_1f;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic        dir;
  logic [71:0] sin;
  logic [31:0] sin_s;

  logic        ov0, ov1, ov2;
  logic [71:0] so0;
  logic [31:0] so1, so2;
  logic [7:0]  md0, md1, md2;

  int n_err    = 0;
  int n_checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  sorter_pipe #(.N(9), .W(8), .APPROX_BITS(0)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .dir(dir),
    .sortIn(sin), .out_valid(ov0), .sortOut(so0), .median(md0));

  sorter_pipe #(.N(4), .W(8), .APPROX_BITS(4)) u_dut_apx (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .dir(dir),
    .sortIn(sin_s), .out_valid(ov1), .sortOut(so1), .median(md1));

  sorter_pipe #(.N(4), .W(8), .APPROX_BITS(0)) u_dut_exact (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .dir(dir),
    .sortIn(sin_s), .out_valid(ov2), .sortOut(so2), .median(md2));

  typedef struct packed {
    logic        v;
    logic        d;
    logic [71:0] data;
  } ent_t;

  ent_t        line    [NK][NMAX];
  logic        exp_ov  [NK];
  logic [71:0] exp_out [NK];
  logic [7:0]  exp_med [NK];

  logic        act_ov  [NK];
  logic [71:0] act_out [NK];
  logic [7:0]  act_med [NK];

  always_comb begin
    act_ov[0]  = ov0;  act_out[0] = so0;             act_med[0] = md0;
    act_ov[1]  = ov1;  act_out[1] = {40'h0, so1};    act_med[1] = md1;
    act_ov[2]  = ov2;  act_out[2] = {40'h0, so2};    act_med[2] = md2;
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // x must be placed strictly before y in the sorted order
  function automatic bit goes_before(input logic [7:0] x, input logic [7:0] y,
                                     input int ab, input logic d);
    int kx, ky;
    kx = int'(x >> ab);
    ky = int'(y >> ab);
    return d ? (kx > ky) : (kx < ky);
  endfunction

  // stable insertion sort of the first n bytes
  function automatic logic [71:0] model_sort(input logic [71:0] v, input int n,
                                             input int ab, input logic d);
    logic [7:0]  e [NMAX];
    logic [7:0]  x;
    int          k;
    logic [71:0] res;
    for (int i = 0; i < NMAX; i++) e[i] = (i < n) ? v[i*8 +: 8] : 8'h00;
    for (int i = 1; i < n; i++) begin
      x = e[i];
      k = i;
      while (k > 0 && goes_before(x, e[k-1], ab, d)) begin
        e[k] = e[k-1];
        k--;
      end
      e[k] = x;
    end
    res = '0;
    for (int i = 0; i < n; i++) res[i*8 +: 8] = e[i];
    return res;
  endfunction

  task automatic model_step();
    ent_t nw;
    ent_t old;
    int   n;
    for (int k = 0; k < NK; k++) begin
      n = N_OF[k];
      if (rst) begin
        for (int i = 0; i < NMAX; i++) line[k][i] = '0;
        exp_ov[k]  = 1'b0;
        exp_out[k] = '0;
        exp_med[k] = '0;
      end else if (enable) begin
        nw.v    = in_valid;
        nw.d    = dir;
        nw.data = (k == 0) ? sin : {40'h0, sin_s};
        old = line[k][n-1];
        for (int i = n - 1; i > 0; i--) line[k][i] = line[k][i-1];
        line[k][0] = nw;
        exp_ov[k] = old.v;
        if (old.v) begin
          exp_out[k] = model_sort(old.data, n, AB_OF[k], old.d);
          exp_med[k] = exp_out[k][(n/2)*8 +: 8];
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (checking) begin
      for (int k = 0; k < NK; k++) begin
        chk($sformatf("out_valid[%0d]", k), 72'(act_ov[k]), 72'(exp_ov[k]));
        chk($sformatf("sortOut[%0d]", k),   act_out[k],      exp_out[k]);
        chk($sformatf("median[%0d]", k),    72'(act_med[k]), 72'(exp_med[k]));
      end
    end
  end

  function automatic logic [71:0] rand_vec(input bit narrow);
    logic [71:0] v;
    for (int i = 0; i < 9; i++)
      v[i*8 +: 8] = narrow ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic drive_one(input logic d);
    logic [71:0] t;
    @(negedge clk);
    in_valid = 1'b1;
    dir      = d;
    sin      = rand_vec($urandom_range(0, 1) == 1);
    t        = rand_vec($urandom_range(0, 1) == 1);
    sin_s    = t[31:0];
  endtask

  initial begin
    logic [71:0] t;
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; dir = 1'b0; sin = '0; sin_s = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 72'(ov0), 72'h0);
    chk("reset_sortOut",   so0,      72'h0);
    chk("reset_median",    72'(md0), 72'h0);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // pin the model to hand-computed results
    chk("model_asc",       model_sort(V1, 9, 0, 1'b0),          EXP_ASC);
    chk("model_desc",      model_sort(V1, 9, 0, 1'b1),          EXP_DESC);
    chk("model_apx_tie",   model_sort({40'h0, VS}, 4, 4, 1'b0), 72'h2a_13_1f_05);
    chk("model_exact_n4",  model_sort({40'h0, VS}, 4, 0, 1'b0), 72'h2a_1f_13_05);

    // single ascending vector, latency N
    @(negedge clk); sin = V1; sin_s = VS; dir = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t1_apx_valid", 72'(ov1), 72'h1);
    chk("t1_apx_out",   {40'h0, so1}, 72'h2a_13_1f_05);
    chk("t1_apx_med",   72'(md1), 72'h13);
    chk("t1_exact_out", {40'h0, so2}, 72'h2a_1f_13_05);
    chk("t1_exact_med", 72'(md2), 72'h1f);
    chk("t1_n9_early",  72'(ov0), 72'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_valid",  72'(ov0), 72'h1);
    chk("t1_out",    so0,      EXP_ASC);
    chk("t1_median", 72'(md0), 72'h09);
    @(posedge clk);
    #1;
    chk("t1_pulse_end", 72'(ov0), 72'h0);
    chk("t1_hold",      so0,      EXP_ASC);

    // same vector descending
    @(negedge clk); sin = V1; dir = 1'b1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t2_valid",  72'(ov0), 72'h1);
    chk("t2_out",    so0,      EXP_DESC);
    chk("t2_median", 72'(md0), 72'h09);

    // eight back-to-back vectors alternating dir
    for (int i = 0; i < 8; i++) drive_one(i[0]);
    @(negedge clk); in_valid = 1'b0;
    repeat (12) @(negedge clk);

    // stall for 3 cycles with 4 vectors in flight; inputs offered during
    // the stall must be dropped
    for (int i = 0; i < 4; i++) drive_one(i[0]);
    for (int i = 0; i < 3; i++) begin
      drive_one(1'b1);
      enable = 1'b0;
    end
    @(negedge clk); enable = 1'b1; in_valid = 1'b0;
    repeat (14) @(negedge clk);

    // reset with 5 vectors in flight
    for (int i = 0; i < 5; i++) drive_one(i[0]);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_async_valid", 72'(ov0), 72'h0);
    chk("rst_async_out",   so0,      72'h0);
    chk("rst_async_med",   72'(md0), 72'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); sin = V1; sin_s = VS; dir = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rst_next_valid", 72'(ov0), 72'h1);
    chk("rst_next_out",   so0,      EXP_ASC);

    // randomized traffic with stalls, bubbles and one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = (i == 1500);
      enable   = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      sin      = rand_vec($urandom_range(0, 1) == 1);
      t        = rand_vec($urandom_range(0, 1) == 1);
      sin_s    = t[31:0];
    end
    @(negedge clk); rst = 1'b0; enable = 1'b1; in_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sorter_pipe.md
Name: sorter_pipe

Overview:
- Parametrised, fully pipelined sorting network for N unsigned W-bit elements packed into one bus.
- Next generation of the 9×8-bit window sorter. Adds parametric N and W, an ascending/descending mode, valid tracking, a global stall, and a median tap.
- Adds an approximate-compare mode that ignores comparator LSBs, for accuracy/area studies.
- Sits between the window buffer and the filter output stage. Accepts one vector per clock.

Parameters:
- N, 9, number of elements; N ≥ 2.
- W, 8, element width in bits.
- APPROX_BITS, 0, number of element LSBs ignored by every comparator; 0 ≤ APPROX_BITS < W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  global advance. When 0, the whole pipeline and all outputs hold.
- in_valid  in  1  sortIn and dir carry a vector this cycle
- dir  in  1  0 = ascending, 1 = descending
- sortIn  in  N*W  element i is at bits [i*W +: W]
- out_valid  out  1  sortOut and median hold a new result
- sortOut  out  N*W  sorted vector, same packing as sortIn
- median  out  W  element floor(N/2) of the sorted result

Behaviour:
- Network is odd-even transposition sort with N rounds.
  - Round r compares pairs (j, j+1): j even when r is even, j odd when r is odd.
  - Each round's result is registered in stage register r.
- Compare-exchange rule:
  - Compare only bits [W-1:APPROX_BITS] of each element.
  - Ascending: swap when lower-index key > higher-index key. Descending: swap when lower-index key < higher-index key.
  - Equal keys never swap, so the sort is stable. With APPROX_BITS > 0, approximately equal elements keep input order.
- Ascending leaves the smallest value in element 0. Descending leaves the largest value in element 0.
- dir is sampled with the data and carried down the pipeline beside each vector. Changing dir between consecutive vectors affects only the new vector.
- The valid bit travels with each vector.
- Latency and throughput:
  - A vector sampled at edge t with enable=1 and in_valid=1 appears on sortOut/median with out_valid=1 after edge t+N (N stages plus the output register).
  - Throughput is 1 vector per cycle.
- Output register:
  - Loads only when enable=1 and the vector leaving the last stage is valid.
  - out_valid = 1 for exactly the cycle after such a load, else 0.
  - sortOut/median hold the last valid result through bubbles.
- Bubbles: in_valid=0 with enable=1 inserts a bubble that advances like data. Its data contents are don't-care and are never presented.
- Stall: enable=0 freezes all stage registers, valid bits and outputs. out_valid holds its current value; any input is dropped. Releasing the stall resumes with no loss and no duplication.
- Reset (any time, including mid-stream): all stage data and valid bits, sortOut and median clear to 0; out_valid clears to 0. In-flight vectors are discarded.
- Arithmetic is unsigned; there is no width growth.

Decomposition:
- Shared package/header sorter_defs holds:
  - direction constants SORT_ASC = 1'b0 and SORT_DESC = 1'b1;
  - the element-slice helper (index → bit offset);
  - the key-mask function for APPROX_BITS.
- One natural sub-module, sorter_cmp_swap. It is a combinational compare-exchange taking params W and APPROX_BITS, inputs a, b and dir, and outputs lo_idx and hi_idx. It is instantiated floor(N/2) or floor((N-1)/2) times per round by generate loops.

Test Plan:
- N=9, W=8, ascending. sortIn=72'h01_09_12_5a_18_04_05_06_11 at edge t → after edge t+9: sortOut=72'h5a_18_12_11_09_06_05_04_01, median=8'h09, out_valid=1 for one cycle.
- Same vector with dir=1 → sortOut=72'h01_04_05_06_09_11_12_18_5a, median=8'h09.
- Eight back-to-back vectors alternating dir, then in_valid=0 → eight consecutive out_valid pulses, each result correct for its own dir. Output holds after the last one.
- Pulse enable=0 for 3 cycles while 4 vectors are in flight → no outputs and all state frozen during the stall. After release, all 4 results appear in order, delayed by exactly 3 cycles.
- N=4, W=8, APPROX_BITS=4, ascending, elements 0..3 = 1f,13,05,2a → sortOut=32'h2a_13_1f_05 (stable tie), median=8'h13. With APPROX_BITS=0 → 32'h2a_1f_13_05, median=8'h1f.
- Assert rst for 1 cycle while 5 vectors are in flight → outputs read 0 immediately (asynchronous). No out_valid from discarded vectors. The next vector sampled after rst falls returns correctly after N+1 edges.
